silife_grid_engine: RTL and testbench

- Parametrised ROWS x COLS Game of Life (B3/S23) cell array with an on-chip evolution controller.
- Successor to the fixed 8x8 grid:
  - arbitrary grid size;
  - selectable toroidal or dead-edge boundary;
  - run, single-step and tick-paced modes;
  - generation counter;
  - still-life auto-halt.
- Sits behind the tile I/O wrapper: the host writes rows via row_select/wr_data and reads rows back.

---
 rtl/silife_grid_engine_if.sv | 25 ++
 rtl/silife_grid_engine.sv | 195 +++++++++++++++++++
 tb/tb_silife_grid_engine.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/silife_grid_engine_if.sv
// silife_grid_engine host row bus.
// Row select, row write and combinational row read-back.
interface silife_grid_engine_if #(
  parameter int COLS     = 8,
  parameter int ROW_BITS = 3
);
  logic [ROW_BITS-1:0] row_select;
  logic                wr_en;
  logic [COLS-1:0]     wr_data;
  logic [COLS-1:0]     rd_data;

  modport master (
    output row_select,
    output wr_en,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  row_select,
    input  wr_en,
    input  wr_data,
    output rd_data
  );
endinterface

// File: rtl/silife_grid_engine.sv
// silife_grid_engine: ROWS x COLS B3/S23 Life array with evolution FSM.
// Optional SILIFE_POPCOUNT_EN adds a registered live-cell population output.
module silife_grid_engine #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int ROW_BITS  = 3,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wrap_en,
  input  logic                 run,
  input  logic                 step,
  input  logic                 tick,
  input  logic                 auto_halt,
  silife_grid_engine_if.slave  bus,
  output logic [GEN_WIDTH-1:0] gen_count,
  output logic                 running,
  output logic                 halted,
`ifdef SILIFE_POPCOUNT_EN
  output logic [$clog2(ROWS*COLS+1)-1:0] population,
`endif
  output logic                 stable
);

  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_d;

  logic [N-1:0] cells;
  logic [N-1:0] nxt;
  logic [N-1:0] cells_d;
  logic         evolve;
  logic         same;
  logic         wr_ok;

  // Cell value at (r,c); off-grid coordinates wrap or read dead.
  function automatic logic live_at(
    input logic [N-1:0] g,
    input int           r,
    input int           c,
    input logic         w
  );
    int rr = r;
    int cc = c;
    if (w) begin
      if (rr < 0) rr = ROWS - 1;
      else if (rr >= ROWS) rr = 0;
      if (cc < 0) cc = COLS - 1;
      else if (cc >= COLS) cc = 0;
    end else if (rr < 0 || rr >= ROWS ||
                 cc < 0 || cc >= COLS) begin
      return 1'b0;
    end
    return g[rr*COLS+cc];
  endfunction

  // Eight-neighbour count, 0..8.
  function automatic logic [3:0] nbr_count(
    input logic [N-1:0] g,
    input int           r,
    input int           c,
    input logic         w
  );
    logic [3:0] n = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0)
          n = n + {3'b000, live_at(g, r + dr, c + dc, w)};
      end
    end
    return n;
  endfunction

  // Full-parallel B3/S23 successor of the whole array.
  always_comb begin
    nxt = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        logic [3:0] n;
        n = nbr_count(cells, r, c, wrap_en);
        nxt[r*COLS+c] = (n == 4'd3) ||
                        (n == 4'd2 && cells[r*COLS+c]);
      end
    end
  end

  assign same = (nxt == cells);

  // Evolve qualifier; any write cycle blocks evolution.
  always_comb begin
    evolve = 1'b0;
    unique case (1'b1)
      state == IDLE: evolve = step && !run;
      state == RUN:  evolve = run && tick;
      default:       evolve = 1'b0;
    endcase
    if (bus.wr_en) evolve = 1'b0;
  end

  // Post-edge grid: evolution, overridden by an in-range row write.
  always_comb begin
    cells_d = evolve ? nxt : cells;
    wr_ok   = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (bus.wr_en && bus.row_select == ROW_BITS'(r)) begin
        cells_d[r*COLS +: COLS] = bus.wr_data;
        wr_ok = 1'b1;
      end
    end
  end

  // Row read-back; out-of-range rows read as zero.
  always_comb begin
    bus.rd_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (bus.row_select == ROW_BITS'(r))
        bus.rd_data = cells[r*COLS +: COLS];
    end
  end

  // Cell array, generation counter and stability flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells     <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
    end else begin
      cells <= cells_d;
      if (evolve) begin
        gen_count <= gen_count + GEN_WIDTH'(1);
      end
      if (wr_ok) begin
        stable <= 1'b0;
      end else if (evolve) begin
        stable <= same;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic; a no-change tick evolution may halt the run.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run)
          state_d = IDLE;
        else if (evolve && same && auto_halt)
          state_d = HALTED;
      end
      HALTED: begin
        if (!run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign running = (state == RUN);
  assign halted  = (state == HALTED);

`ifdef SILIFE_POPCOUNT_EN
  localparam int PW = $clog2(N + 1);

  logic [PW-1:0] pop_d;

  // Live-cell count of the registered grid.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < N; i++)
      pop_d = pop_d + PW'(cells[i]);
  end

  // Population register, one cycle behind the grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) population <= '0;
    else        population <= pop_d;
  end
`endif

endmodule

// File: tb/tb_silife_grid_engine.sv
// tb_silife_grid_engine: directed vectors for silife_grid_engine.
// 8x8 grid, ROW_BITS=4 (out-of-range rows), GEN_WIDTH=4 (counter wrap).
module tb_silife_grid_engine;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int RB   = 4;
  localparam int GW   = 4;

  localparam logic [63:0] G_ZERO  = 64'h0;
  localparam logic [63:0] G_HORIZ = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] G_VERT  = 64'h0000_0008_0808_0000;
  localparam logic [63:0] G_WRAP  = 64'h0100_0000_0000_0101;
  localparam logic [63:0] G_BLOCK = 64'h0000_0000_0000_0303;
  localparam logic [63:0] G_WP    = 64'h0000_FF00_1C00_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wrap_en;
  logic          run;
  logic          step;
  logic          tick;
  logic          auto_halt;
  logic [GW-1:0] gen_count;
  logic          running;
  logic          halted;
  logic          stable;
`ifdef SILIFE_POPCOUNT_EN
  logic [6:0]    population;
`endif

  int total = 0;
  int bad   = 0;

  silife_grid_engine_if #(.COLS(COLS), .ROW_BITS(RB)) bus ();

  silife_grid_engine #(
    .ROWS(ROWS),
    .COLS(COLS),
    .ROW_BITS(RB),
    .GEN_WIDTH(GW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wrap_en(wrap_en),
    .run(run),
    .step(step),
    .tick(tick),
    .auto_halt(auto_halt),
    .bus(bus),
    .gen_count(gen_count),
    .running(running),
    .halted(halted),
`ifdef SILIFE_POPCOUNT_EN
    .population(population),
`endif
    .stable(stable)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_row(input int r, input logic [7:0] d);
    bus.row_select = RB'(r);
    bus.wr_data    = d;
    bus.wr_en      = 1'b1;
    cyc();
    bus.wr_en      = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    cyc();
    step = 1'b0;
  endtask

  task automatic chk_rows(input string tag, input logic [63:0] g);
    for (int r = 0; r < ROWS; r++) begin
      bus.row_select = RB'(r);
      #1;
      chk($sformatf("%s_r%0d", tag, r),
          {24'h0, bus.rd_data}, {24'h0, g[r*8 +: 8]});
    end
  endtask

  task automatic do_reset();
    run = 1'b0; tick = 1'b0; step = 1'b0;
    bus.wr_en = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wrap_en = 1'b0; run = 1'b0;
    step = 1'b0; tick = 1'b0; auto_halt = 1'b0;
    bus.row_select = '0; bus.wr_en = 1'b0; bus.wr_data = '0;
    #3;
    chk("rst_gen", 32'(gen_count), 32'd0);
    chk("rst_stable", 32'(stable), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk_rows("rst", G_ZERO);
    cyc();
    rst_n = 1'b1;

    // blinker, toroidal
    wrap_en = 1'b1;
    wr_row(3, 8'h1C);
`ifdef SILIFE_POPCOUNT_EN
    cyc();
    chk("pop_blinker", 32'(population), 32'd3);
`endif
    do_step();
    chk_rows("blk1", G_VERT);
    chk("blk1_gen", 32'(gen_count), 32'd1);
    chk("blk1_stable", 32'(stable), 32'd0);
    do_step();
    chk_rows("blk2", G_HORIZ);
    chk("blk2_gen", 32'(gen_count), 32'd2);

    // edge wrap vs dead edge
    do_reset();
    wrap_en = 1'b1;
    wr_row(0, 8'h83);
    do_step();
    chk_rows("wrap", G_WRAP);
    do_reset();
    wrap_en = 1'b0;
    wr_row(0, 8'h83);
    do_step();
    chk_rows("dead", G_ZERO);
`ifdef SILIFE_POPCOUNT_EN
    cyc();
    chk("pop_dead", 32'(population), 32'd0);
`endif

    // auto-halt on a still-life block
    do_reset();
    wrap_en = 1'b0;
    auto_halt = 1'b1;
    wr_row(0, 8'h03);
    wr_row(1, 8'h03);
    run = 1'b1;
    cyc();
    chk("ah_running", 32'(running), 32'd1);
    chk("ah_gen0", 32'(gen_count), 32'd0);
    for (int i = 0; i < 40 && !halted; i++) begin
      tick = (i % 4 == 3);
      cyc();
    end
    tick = 1'b0;
    chk("ah_halted", 32'(halted), 32'd1);
    chk("ah_notrun", 32'(running), 32'd0);
    chk("ah_gen", 32'(gen_count), 32'd1);
    chk("ah_stable", 32'(stable), 32'd1);
    chk_rows("ah", G_BLOCK);
    wr_row(7, 8'h00);
    chk("ah_wr_stable", 32'(stable), 32'd0);
    chk("ah_wr_halted", 32'(halted), 32'd1);
    chk("ah_wr_gen", 32'(gen_count), 32'd1);
    run = 1'b0;
    cyc();
    chk("ah_idle_h", 32'(halted), 32'd0);
    chk("ah_idle_r", 32'(running), 32'd0);
    auto_halt = 1'b0;

    // write wins over a tick evolution
    do_reset();
    wrap_en = 1'b1;
    wr_row(3, 8'h1C);
    run = 1'b1;
    cyc();
    tick = 1'b1;
    bus.row_select = RB'(5);
    bus.wr_data = 8'hFF;
    bus.wr_en = 1'b1;
    cyc();
    bus.wr_en = 1'b0;
    tick = 1'b0;
    chk_rows("wp", G_WP);
    chk("wp_gen", 32'(gen_count), 32'd0);
    chk("wp_stable", 32'(stable), 32'd0);
    chk("wp_running", 32'(running), 32'd1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("wp_tick_gen", 32'(gen_count), 32'd1);

    // out-of-range row
    do_reset();
    wr_row(12, 8'hFF);
    bus.row_select = RB'(12);
    #1;
    chk("oor_rd", 32'(bus.rd_data), 32'd0);
    chk_rows("oor", G_ZERO);

    // counter wrap at GEN_WIDTH=4
    do_reset();
    wrap_en = 1'b1;
    wr_row(3, 8'h1C);
    repeat (15) do_step();
    chk("cw_gen15", 32'(gen_count), 32'd15);
    chk_rows("cw15", G_VERT);
    do_step();
    chk("cw_gen0", 32'(gen_count), 32'd0);
    chk_rows("cw16", G_HORIZ);

    // async reset in the middle of a run
    run = 1'b1;
    cyc();
    tick = 1'b1;
    repeat (3) cyc();
    chk("ar_gen3", 32'(gen_count), 32'd3);
    chk("ar_run", 32'(running), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gen", 32'(gen_count), 32'd0);
    chk("ar_running", 32'(running), 32'd0);
    chk("ar_halted", 32'(halted), 32'd0);
    chk("ar_stable", 32'(stable), 32'd0);
    chk_rows("ar", G_ZERO);
    run = 1'b0;
    tick = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("ar_idle", 32'(running), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
